// File: rtl/edge_pkg.sv
// Shared definitions for the Sobel edge-detection path: FSM state encoding,
// default pixel width, 3x3 window size and the Sobel coefficient tables.
package edge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_CALC  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int WORD_DEF  = 8;
   localparam int KWIN      = 9;
   // Headroom for the gradient sums: |Gx|+|Gy| <= 8*(2^WORD-1) < 2^(WORD+3)
   localparam int SAT_EXTRA = 3;

   // Window index k maps to (row k/3, col k%3) of the 3x3 neighbourhood
   localparam int GX_COEF [KWIN] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
   localparam int GY_COEF [KWIN] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

   // Width of the signed gradients and of the unsaturated magnitude
   function automatic int sat_width(input int word);
      return word + SAT_EXTRA;
   endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Combinational Sobel operator: 3x3 window in, |Gx|+|Gy| out both raw
// (for threshold compare) and saturated to the pixel width.
module sobel_kernel
   import edge_pkg::*;
#(
   parameter  int WORD = WORD_DEF,
   localparam int SW   = sat_width(WORD)
) (
   input  logic [KWIN-1:0][WORD-1:0] i_win,
   output logic [WORD-1:0]           o_sat,
   output logic [SW-1:0]             o_mag
);

   logic signed [SW-1:0] w_gx_term [KWIN];
   logic signed [SW-1:0] w_gy_term [KWIN];
   logic signed [SW-1:0] w_gx;
   logic signed [SW-1:0] w_gy;
   logic        [SW-1:0] w_abs_gx;
   logic        [SW-1:0] w_abs_gy;
   logic        [SW-1:0] w_mag;

   // Coefficients are only 0, +-1, +-2, so each product is a shift/negate
   function automatic logic signed [SW-1:0] coef_term(input logic [WORD-1:0] pix,
                                                       input int coef);
      logic signed [SW-1:0] ext;
      ext = $signed({{SAT_EXTRA{1'b0}}, pix});
      case (coef)
         1:       coef_term = ext;
         2:       coef_term = ext <<< 1;
         -1:      coef_term = -ext;
         -2:      coef_term = -(ext <<< 1);
         default: coef_term = '0;
      endcase
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < KWIN; gi++) begin : g_term
         assign w_gx_term[gi] = coef_term(i_win[gi], GX_COEF[gi]);
         assign w_gy_term[gi] = coef_term(i_win[gi], GY_COEF[gi]);
      end
   endgenerate

   // Sum the weighted taps into the two signed gradients
   always_comb begin
      w_gx = '0;
      w_gy = '0;
      for (int i = 0; i < KWIN; i++) begin
         w_gx = w_gx + w_gx_term[i];
         w_gy = w_gy + w_gy_term[i];
      end
   end

   // Gradients never reach the most negative code, so negation cannot overflow
   assign w_abs_gx = w_gx[SW-1] ? SW'(-w_gx) : SW'(w_gx);
   assign w_abs_gy = w_gy[SW-1] ? SW'(-w_gy) : SW'(w_gy);
   assign w_mag    = w_abs_gx + w_abs_gy;

   assign o_mag = w_mag;
   assign o_sat = (|w_mag[SW-1:WORD]) ? {WORD{1'b1}} : w_mag[WORD-1:0];

endmodule

// File: rtl/sobel_frame_engine.sv
// Frame-level Sobel engine: walks the source frame in raster order, fetches
// each interior 3x3 window through the async source read port, and writes one
// result byte per pixel (border pixels are written as 0 without any reads).
// Optional build macro EDGE_THRESH_EN: binarise interior results against thresh_i.
module sobel_frame_engine
   import edge_pkg::*;
#(
   parameter  int WORD  = WORD_DEF,
   parameter  int IMG_W = 16,
   parameter  int IMG_H = 16,
   localparam int ADR_W = $clog2(IMG_W * IMG_H)
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             start_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [ADR_W-1:0] src_adr_o,
   input  logic [WORD-1:0]  src_data_i,
   output logic             dst_wr_o,
   output logic [ADR_W-1:0] dst_adr_o,
   output logic [WORD-1:0]  dst_data_o,
   input  logic [WORD-1:0]  thresh_i
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam int KW = $clog2(KWIN);
   localparam int SW = sat_width(WORD);

   localparam logic [XW-1:0]    X_MAX   = XW'(IMG_W - 1);
   localparam logic [YW-1:0]    Y_MAX   = YW'(IMG_H - 1);
   localparam logic [ADR_W-1:0] IMG_W_A = ADR_W'(IMG_W);
   localparam logic [KW-1:0]    K_LAST  = KW'(KWIN - 1);

   state_t              r_state;
   logic [XW-1:0]       r_x;
   logic [YW-1:0]       r_y;
   logic [KW-1:0]       r_k;
   logic [WORD-1:0]     r_win [KWIN];
   logic [ADR_W-1:0]    r_src_adr;
   logic [ADR_W-1:0]    r_dst_adr;
   logic [WORD-1:0]     r_dst_data;
   logic                r_dst_wr;
   logic                r_busy;
   logic                r_done;

   logic [KWIN-1:0][WORD-1:0] w_win;
   logic [WORD-1:0]     w_sat;
   logic [SW-1:0]       w_mag;
   logic [WORD-1:0]     w_result;
   logic                w_last;
   logic                w_enter;
   logic [XW-1:0]       w_tx;
   logic [YW-1:0]       w_ty;
   logic                w_t_border;
   logic [ADR_W-1:0]    w_t_adr;
   logic [ADR_W-1:0]    w_t_src;
   logic                w_row_end;

   genvar gi;
   generate
      for (gi = 0; gi < KWIN; gi++) begin : g_win_pack
         assign w_win[gi] = r_win[gi];
      end
   endgenerate

   sobel_kernel #(
      .WORD (WORD)
   ) u_kernel (
      .i_win (w_win),
      .o_sat (w_sat),
      .o_mag (w_mag)
   );

`ifdef EDGE_THRESH_EN
   // Binary edge map: full-scale where the raw magnitude reaches the threshold
   assign w_result = (w_mag >= {{SAT_EXTRA{1'b0}}, thresh_i}) ? {WORD{1'b1}} : '0;
   logic w_unused_cfg;
   assign w_unused_cfg = ^w_sat;
`else
   assign w_result = w_sat;
   logic w_unused_cfg;
   assign w_unused_cfg = ^{thresh_i, w_mag};
`endif

   // Next pixel to visit: (0,0) when launching from IDLE, raster successor otherwise
   always_comb begin
      w_last = (r_x == X_MAX) && (r_y == Y_MAX);
      w_tx   = '0;
      w_ty   = '0;
      if (r_state == ST_WRITE) begin
         if (r_x == X_MAX) begin
            w_tx = '0;
            w_ty = r_y + YW'(1);
         end else begin
            w_tx = r_x + XW'(1);
            w_ty = r_y;
         end
      end
   end

   assign w_t_border = (w_tx == '0) || (w_tx == X_MAX) || (w_ty == '0) || (w_ty == Y_MAX);
   assign w_t_adr    = ADR_W'(w_ty) * IMG_W_A + ADR_W'(w_tx);
   // Top-left tap of the window; only meaningful for interior pixels
   assign w_t_src    = w_t_adr - IMG_W_A - ADR_W'(1);
   assign w_enter    = ((r_state == ST_IDLE) && start_i) || ((r_state == ST_WRITE) && !w_last);
   // After the third tap of a row, jump to the first tap of the next row
   assign w_row_end  = (r_k == KW'(2)) || (r_k == KW'(5));

   // Frame FSM: counters, address generation and registered outputs
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_state    <= ST_IDLE;
         r_x        <= '0;
         r_y        <= '0;
         r_k        <= '0;
         r_src_adr  <= '0;
         r_dst_adr  <= '0;
         r_dst_data <= '0;
         r_dst_wr   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_dst_wr <= 1'b0;
         r_done   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  r_busy <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (r_k == K_LAST) begin
                  r_state <= ST_CALC;
               end else begin
                  r_k       <= r_k + KW'(1);
                  r_src_adr <= w_row_end ? (r_src_adr + IMG_W_A - ADR_W'(2))
                                         : (r_src_adr + ADR_W'(1));
               end
            end
            ST_CALC: begin
               r_state    <= ST_WRITE;
               r_dst_wr   <= 1'b1;
               r_dst_data <= w_result;
            end
            ST_WRITE: begin
               if (w_last) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase

         // Entering a pixel: border goes straight to WRITE, interior starts fetching
         if (w_enter) begin
            r_x       <= w_tx;
            r_y       <= w_ty;
            r_k       <= '0;
            r_dst_adr <= w_t_adr;
            if (w_t_border) begin
               r_state    <= ST_WRITE;
               r_dst_wr   <= 1'b1;
               r_dst_data <= '0;
            end else begin
               r_state   <= ST_FETCH;
               r_src_adr <= w_t_src;
            end
         end
      end
   end

   // Window register file: capture the async source data for tap k
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < KWIN; i++) begin
            r_win[i] <= '0;
         end
      end else if (r_state == ST_FETCH) begin
         r_win[r_k] <= src_data_i;
      end
   end

   assign busy_o     = r_busy;
   assign done_o     = r_done;
   assign src_adr_o  = r_src_adr;
   assign dst_wr_o   = r_dst_wr;
   assign dst_adr_o  = r_dst_adr;
   assign dst_data_o = r_dst_data;

endmodule

// File: tb/tb_sobel_frame_engine.sv
// Bench for sobel_frame_engine on a 4x4 frame with async-read source memory
// and a destination memory; results are compared with a per-pixel Sobel model.
module tb_sobel_frame_engine;

   localparam int WORD  = 8;
   localparam int IMG_W = 4;
   localparam int IMG_H = 4;
   localparam int NPIX  = IMG_W * IMG_H;
   localparam int ADR_W = $clog2(NPIX);
   localparam int FRAME_CYC = (IMG_W - 2) * (IMG_H - 2) * 11 + (2 * IMG_W + 2 * IMG_H - 4) + 1;

   logic             clk;
   logic             rstn;
   logic             start;
   logic             busy;
   logic             done;
   logic [ADR_W-1:0] src_adr;
   logic [WORD-1:0]  src_data;
   logic             dst_wr;
   logic [ADR_W-1:0] dst_adr;
   logic [WORD-1:0]  dst_data;
   logic [WORD-1:0]  thresh;

   logic [WORD-1:0]  src_mem [NPIX];
   logic [WORD-1:0]  dst_mem [NPIX];
   logic             clr_dst;
   int               wr_total   = 0;
   int               done_total = 0;
   int               n_vec  = 0;
   int               n_miss = 0;

   sobel_frame_engine #(
      .WORD  (WORD),
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) dut (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .start_i    (start),
      .busy_o     (busy),
      .done_o     (done),
      .src_adr_o  (src_adr),
      .src_data_i (src_data),
      .dst_wr_o   (dst_wr),
      .dst_adr_o  (dst_adr),
      .dst_data_o (dst_data),
      .thresh_i   (thresh)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign src_data = src_mem[src_adr];

   always @(posedge clk) begin
      if (clr_dst) begin
         for (int i = 0; i < NPIX; i++) dst_mem[i] <= 8'hA5;
      end else if (dst_wr) begin
         dst_mem[dst_adr] <= dst_data;
      end
      if (dst_wr) wr_total <= wr_total + 1;
      if (done) done_total <= done_total + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_miss++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int pix(int x, int y);
      return int'(src_mem[y * IMG_W + x]);
   endfunction

   // Reference Sobel on the source frame, straight from the operator definition
   function automatic int model_px(int x, int y, int th);
      int gx, gy, mag;
      if (x == 0 || y == 0 || x == IMG_W - 1 || y == IMG_H - 1) return 0;
      gx = (pix(x+1, y-1) + 2 * pix(x+1, y) + pix(x+1, y+1))
         - (pix(x-1, y-1) + 2 * pix(x-1, y) + pix(x-1, y+1));
      gy = (pix(x-1, y+1) + 2 * pix(x, y+1) + pix(x+1, y+1))
         - (pix(x-1, y-1) + 2 * pix(x, y-1) + pix(x+1, y-1));
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef EDGE_THRESH_EN
      return (mag >= th) ? 255 : 0;
`else
      if (th < 0) return 0;
      return (mag > 255) ? 255 : mag;
`endif
   endfunction

   task automatic check_frame(input string tag, input int th);
      for (int y = 0; y < IMG_H; y++) begin
         for (int x = 0; x < IMG_W; x++) begin
            chk($sformatf("%s px(%0d,%0d)", tag, x, y), 32'(dst_mem[y * IMG_W + x]),
                32'(model_px(x, y, th)));
         end
      end
   endtask

   task automatic start_pulse();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Launch one pass and check latency, write count, done pulse and contents
   task automatic run_frame(input string tag, input int th);
      int n, w0, d0;
      logic busy1;
      thresh = WORD'(th);
      @(negedge clk);
      clr_dst = 1'b1;
      @(negedge clk);
      clr_dst = 1'b0;
      w0 = wr_total;
      d0 = done_total;
      busy1 = 1'b0;
      start_pulse();
      n = 1;
      #1;
      busy1 = busy;
      while (!done && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, " done latency"}, n, FRAME_CYC);
      chk({tag, " busy after start"}, 32'(busy1), 1);
      @(posedge clk);
      #1;
      chk({tag, " done one pulse"}, 32'(done), 0);
      chk({tag, " busy cleared"}, 32'(busy), 0);
      chk({tag, " write count"}, wr_total - w0, NPIX);
      chk({tag, " done count"}, done_total - d0, 1);
      check_frame(tag, th);
   endtask

   initial begin
      int n, w0, d0;
      rstn    = 1'b0;
      start   = 1'b0;
      clr_dst = 1'b0;
      thresh  = '0;
      for (int i = 0; i < NPIX; i++) src_mem[i] = '0;

      // Reset state, with start_i held high: reset wins
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      chk("rst busy", 32'(busy), 0);
      chk("rst done", 32'(done), 0);
      chk("rst dst_wr", 32'(dst_wr), 0);
      chk("rst src_adr", 32'(src_adr), 0);
      chk("rst dst_adr", 32'(dst_adr), 0);
      chk("rst dst_data", 32'(dst_data), 0);
      @(negedge clk);
      start = 1'b0;
      rstn  = 1'b1;
      @(posedge clk);
      #1;
      chk("idle after rst busy", 32'(busy), 0);

      // Flat frame
      for (int i = 0; i < NPIX; i++) src_mem[i] = 8'd100;
      run_frame("flat", 128);

      // Vertical step
      for (int i = 0; i < NPIX; i++) src_mem[i] = ((i % IMG_W) >= 2) ? 8'd255 : 8'd0;
      run_frame("step", 128);
      chk("step (1,1) const", 32'(dst_mem[5]), 255);
      chk("step (2,2) const", 32'(dst_mem[10]), 255);

      // Horizontal ramp
      for (int i = 0; i < NPIX; i++) src_mem[i] = WORD'((i % IMG_W) * 10);
`ifdef EDGE_THRESH_EN
      run_frame("ramp th50", 50);
      chk("ramp th50 const", 32'(dst_mem[6]), 255);
      run_frame("ramp th100", 100);
      chk("ramp th100 const", 32'(dst_mem[6]), 0);
`else
      run_frame("ramp", 0);
      chk("ramp (2,1) const", 32'(dst_mem[6]), 80);
      chk("ramp (1,2) const", 32'(dst_mem[9]), 80);
`endif

      // Random frames: full range and small values (no saturation)
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < NPIX; i++) src_mem[i] = WORD'($urandom_range(255, 0));
         run_frame($sformatf("rand%0d", f), int'($urandom_range(255, 0)));
      end
      for (int i = 0; i < NPIX; i++) src_mem[i] = WORD'($urandom_range(31, 0));
      run_frame("rand small", int'($urandom_range(200, 0)));

      // Reset in the middle of a pass aborts it
      w0 = wr_total;
      start_pulse();
      repeat (19) @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
      @(posedge clk);
      #1;
      chk("abort busy", 32'(busy), 0);
      chk("abort dst_wr", 32'(dst_wr), 0);
      @(negedge clk);
      rstn = 1'b1;
      w0 = wr_total;
      d0 = done_total;
      repeat (80) @(posedge clk);
      #1;
      chk("abort no writes", wr_total - w0, 0);
      chk("abort no done", done_total - d0, 0);
      for (int i = 0; i < NPIX; i++) src_mem[i] = WORD'($urandom_range(255, 0));
      run_frame("post abort", 128);

      // Start while busy and during DONE are ignored
      @(negedge clk);
      clr_dst = 1'b1;
      @(negedge clk);
      clr_dst = 1'b0;
      w0 = wr_total;
      d0 = done_total;
      start_pulse();
      n = 1;
      #1;
      while (!done && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 10) start = 1'b1;
         if (n == 11) start = 1'b0;
      end
      chk("restart done latency", n, FRAME_CYC);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (70) @(posedge clk);
      #1;
      chk("restart write count", wr_total - w0, NPIX);
      chk("restart done count", done_total - d0, 1);
      chk("restart busy idle", 32'(busy), 0);
      check_frame("restart", 128);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
